// File: rtl/wb_regfile.sv
// Purpose: 32x32 register file with write-back mux, same-cycle write bypass and commit trace outputs.
// Latency: reads and WBdata_o are combinational (0 cycles); writes and commit_* update on the next rising edge.
// Backpressure: none; every write request is accepted in the cycle it is presented.
module wb_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] MEMdata_i,
  input  logic        MemtoReg_i,
  input  logic        RegWrite_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  output logic [31:0] RS1data_o,
  output logic [31:0] RS2data_o,
  output logic [31:0] WBdata_o,
  output logic        commit_valid_o,
  output logic [4:0]  commit_addr_o,
  output logic [31:0] commit_data_o,
  output logic [31:0] commit_count_o
);

  logic [31:0] regs_q [32];
  logic        wr_req;
  logic        wr_commit;
  logic        commit_valid_q;
  logic [4:0]  commit_addr_q;
  logic [31:0] commit_data_q;
  logic [31:0] commit_count_q;

  // Write-back source select; intentionally not gated by RegWrite_i so forwarding sees it always.
  assign WBdata_o = MemtoReg_i ? MEMdata_i : ALUresult_i;

  // A live write request (reset suppresses it); it commits only when not targeting x0.
  assign wr_req    = !rst_i && RegWrite_i;
  assign wr_commit = wr_req && (RDaddr_i != 5'd0);

  // Per-port read: x0 is hardwired zero, a same-cycle write to the address is bypassed, else the array.
  always_comb begin
    RS1data_o = regs_q[RS1addr_i];
    if (RS1addr_i == 5'd0) begin
      RS1data_o = 32'd0;
    end else if (wr_req && (RDaddr_i == RS1addr_i)) begin
      RS1data_o = WBdata_o;
    end
  end

  // Second read port, bypassed independently of the first.
  always_comb begin
    RS2data_o = regs_q[RS2addr_i];
    if (RS2addr_i == 5'd0) begin
      RS2data_o = 32'd0;
    end else if (wr_req && (RDaddr_i == RS2addr_i)) begin
      RS2data_o = WBdata_o;
    end
  end

  // Register array: clear everything on reset, otherwise store committed writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (wr_commit) begin
      regs_q[RDaddr_i] <= WBdata_o;
    end
  end

  // Commit trace: valid pulses per committed write, address/data hold between commits, count wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_valid_q <= 1'b0;
      commit_addr_q  <= 5'd0;
      commit_data_q  <= 32'd0;
      commit_count_q <= 32'd0;
    end else begin
      commit_valid_q <= wr_commit;
      if (wr_commit) begin
        commit_addr_q  <= RDaddr_i;
        commit_data_q  <= WBdata_o;
        commit_count_q <= commit_count_q + 32'd1;
      end
    end
  end

  assign commit_valid_o = commit_valid_q;
  assign commit_addr_o  = commit_addr_q;
  assign commit_data_o  = commit_data_q;
  assign commit_count_o = commit_count_q;

endmodule
